// File: rtl/button_seq_pkg.sv
// Shared types and constants for the button PIO event sequencer.
// Covers the FSM state encoding, PIO register map and button-to-command mapping.
package button_seq_pkg;

  typedef enum logic [2:0] {
    INIT_MASK,
    IDLE,
    RD_REQ,
    RD_WAIT,
    CLR,
    HOLD,
    FLUSH
  } state_t;

  // PIO register map
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  // Button index doubles as the command id
  localparam logic [1:0] BTN_PLAY = 2'd0;
  localparam logic [1:0] BTN_NEXT = 2'd1;
  localparam logic [1:0] BTN_PREV = 2'd2;

endpackage

// File: rtl/button_cmd_queue.sv
// Pending-button register turned into a valid/ready token stream, lowest index first.
// A set and a clear of the same bit in one cycle leaves the bit set and is not an overflow.
module button_cmd_queue #(
  parameter int NUM_BTN = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               set_en,
  input  logic [NUM_BTN-1:0] set_bits,
  input  logic               cmd_ready,
  output logic               cmd_valid,
  output logic [1:0]         cmd_id,
  output logic               overflow
);

  logic [NUM_BTN-1:0] pending_reg, pending_next;
  logic [NUM_BTN-1:0] clr_bits, set_mask;
  logic               cmd_valid_reg;
  logic [1:0]         cmd_id_reg, cmd_id_next;
  logic               overflow_reg, overflow_next;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_clr
      assign clr_bits[gi] = cmd_valid_reg & cmd_ready & (cmd_id_reg == 2'(gi));
    end
  endgenerate

  always_comb begin
    set_mask      = set_en ? set_bits : '0;
    pending_next  = (pending_reg & ~clr_bits) | set_mask;
    overflow_next = |(pending_reg & set_mask & ~clr_bits);
    cmd_id_next   = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (pending_next[i]) cmd_id_next = 2'(i);
    end
  end

  // Token outputs are computed from the next pending value so they stay registered
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_reg   <= '0;
      cmd_valid_reg <= 1'b0;
      cmd_id_reg    <= '0;
      overflow_reg  <= 1'b0;
    end else begin
      pending_reg   <= pending_next;
      cmd_valid_reg <= |pending_next;
      cmd_id_reg    <= cmd_id_next;
      overflow_reg  <= overflow_next;
    end
  end

  assign cmd_valid = cmd_valid_reg;
  assign cmd_id    = cmd_id_reg;
  assign overflow  = overflow_reg;

endmodule

// File: rtl/button_event_sequencer.sv
// Avalon-MM master servicing the 3-button PIO: programs the IRQ mask, reads and clears
// edge captures, waits out switch bounce, then flushes; captured edges become command tokens.
module button_event_sequencer
  import button_seq_pkg::*;
#(
  parameter int                 NUM_BTN        = 3,
  parameter logic [NUM_BTN-1:0] IRQ_MASK       = 3'b111,
  parameter int                 HOLDOFF_CYCLES = 2500000,
  parameter int                 CNT_W          = 22
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        irq,
  output logic [1:0]  pio_address,
  output logic        pio_chipselect,
  output logic        pio_write_n,
  output logic [31:0] pio_writedata,
  input  logic [31:0] pio_readdata,
  output logic        cmd_valid,
  output logic [1:0]  cmd_id,
  input  logic        cmd_ready,
  output logic        busy,
  output logic        overflow
);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [1:0]         addr_reg, addr_next;
  logic               cs_reg, cs_next;
  logic               wr_n_reg, wr_n_next;
  logic [NUM_BTN-1:0] wdata_reg, wdata_next;
  logic               busy_reg;
  logic [NUM_BTN-1:0] cap_now;
  logic               unused_readdata;

  assign cap_now         = pio_readdata[NUM_BTN-1:0] & IRQ_MASK;
  assign unused_readdata = ^pio_readdata[31:NUM_BTN];

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      // Stay until the mask write strobe has actually been on the bus
      INIT_MASK: if (cs_reg) state_next = FLUSH;
      IDLE:      if (irq && enable) state_next = RD_REQ;
      RD_REQ:    state_next = RD_WAIT;
      RD_WAIT:   state_next = CLR;
      CLR: begin
        cnt_next   = CNT_W'(HOLDOFF_CYCLES - 1);
        state_next = HOLD;
      end
      HOLD: begin
        if (cnt_reg == '0) state_next = FLUSH;
        else               cnt_next   = cnt_reg - 1'b1;
      end
      FLUSH:     state_next = IDLE;
      default:   state_next = INIT_MASK;
    endcase
  end

  // Bus outputs are registered from the state being entered, so each access is on the
  // bus during its own state and registered readdata lands in RD_WAIT.
  always_comb begin
    addr_next  = ADDR_DATA;
    cs_next    = 1'b0;
    wr_n_next  = 1'b1;
    wdata_next = '0;
    case (state_next)
      INIT_MASK: begin
        addr_next  = ADDR_MASK;
        cs_next    = 1'b1;
        wr_n_next  = 1'b0;
        wdata_next = IRQ_MASK;
      end
      RD_REQ: addr_next = ADDR_EDGE;
      CLR: begin
        addr_next  = ADDR_EDGE;
        cs_next    = 1'b1;
        wr_n_next  = 1'b0;
        wdata_next = cap_now;
      end
      FLUSH: begin
        addr_next  = ADDR_EDGE;
        cs_next    = 1'b1;
        wr_n_next  = 1'b0;
        wdata_next = '1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= INIT_MASK;
      cnt_reg   <= '0;
      addr_reg  <= ADDR_DATA;
      cs_reg    <= 1'b0;
      wr_n_reg  <= 1'b1;
      wdata_reg <= '0;
      busy_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      addr_reg  <= addr_next;
      cs_reg    <= cs_next;
      wr_n_reg  <= wr_n_next;
      wdata_reg <= wdata_next;
      busy_reg  <= (state_next != IDLE);
    end
  end

  button_cmd_queue #(
    .NUM_BTN(NUM_BTN)
  ) u_cmd_queue (
    .clk      (clk),
    .reset    (reset),
    .set_en   (state_reg == RD_WAIT),
    .set_bits (cap_now),
    .cmd_ready(cmd_ready),
    .cmd_valid(cmd_valid),
    .cmd_id   (cmd_id),
    .overflow (overflow)
  );

  assign pio_address    = addr_reg;
  assign pio_chipselect = cs_reg;
  assign pio_write_n    = wr_n_reg;
  assign pio_writedata  = {{(32 - NUM_BTN){1'b0}}, wdata_reg};
  assign busy           = busy_reg;

endmodule

// File: tb/tb_button_event_sequencer.sv
// Bench for button_event_sequencer: a PIO slave model plus a timeline-based reference
// model of the bus sequence and the pending-token set, compared every cycle.
module tb_button_event_sequencer;

  localparam int H      = 16;
  localparam int M_INIT = 0;
  localparam int M_IDLE = 1;
  localparam int M_SVC  = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        irq = 1'b0;
  logic [31:0] pio_readdata = 32'h0;
  logic        cmd_ready = 1'b0;
  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;
  logic        cmd_valid;
  logic [1:0]  cmd_id;
  logic        busy;
  logic        overflow;

  button_event_sequencer #(
    .NUM_BTN(3), .IRQ_MASK(3'b111), .HOLDOFF_CYCLES(H), .CNT_W(5)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .irq(irq),
    .pio_address(pio_address), .pio_chipselect(pio_chipselect),
    .pio_write_n(pio_write_n), .pio_writedata(pio_writedata),
    .pio_readdata(pio_readdata), .cmd_valid(cmd_valid), .cmd_id(cmd_id),
    .cmd_ready(cmd_ready), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit armed = 1'b0;

  // Reference model: sequence kind + offset into its fixed timeline, plus pending set
  int         mode = M_INIT;
  int         off = 0;
  logic [2:0] m_cap = 3'b000;
  logic [2:0] pend = 3'b000;
  logic       ov_e = 1'b0;
  // PIO slave model
  logic [2:0] ec = 3'b000;
  logic [2:0] pio_mask = 3'b000;

  int wlog[$], wcyc[$], acc[$], acc_cyc[$];
  int ov_cnt = 0, rd_cnt = 0, stall_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0d, required %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int lowest(input logic [2:0] v);
    for (int i = 0; i < 3; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic int q_at(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic expected_bus(output int ea, output int ecs, output int ewn,
                              output int ewd, output int eb);
    ea = 0; ecs = 0; ewn = 1; ewd = 0; eb = 1;
    if (mode == M_IDLE) begin
      eb = 0;
    end else if (mode == M_INIT) begin
      if (off >= 1) begin
        ecs = 1; ewn = 0; ewd = 7; ea = (off == 1) ? 2 : 3;
      end
    end else begin
      if (off == 1) ea = 3;
      else if (off == 3) begin ea = 3; ecs = 1; ewn = 0; ewd = int'(m_cap); end
      else if (off == 4 + H) begin ea = 3; ecs = 1; ewn = 0; ewd = 7; end
    end
  endtask

  task automatic compare_outputs();
    int ea, ecs, ewn, ewd, eb;
    expected_bus(ea, ecs, ewn, ewd, eb);
    chk("pio_address", int'(pio_address), ea);
    chk("pio_chipselect", int'(pio_chipselect), ecs);
    chk("pio_write_n", int'(pio_write_n), ewn);
    chk("pio_writedata", int'(pio_writedata), ewd);
    chk("busy", int'(busy), eb);
    chk("cmd_valid", int'(cmd_valid), (pend != 3'b000) ? 1 : 0);
    chk("cmd_id", int'(cmd_id), lowest(pend));
    chk("overflow", int'(overflow), int'(ov_e));
  endtask

  task automatic model_step(input logic rdy, input logic en, input logic rst);
    logic [2:0] clr, set;
    if (rst) begin
      mode = M_INIT; off = 0; pend = 3'b000; ov_e = 1'b0;
      return;
    end
    clr  = (pend != 3'b000 && rdy) ? 3'(1 << lowest(pend)) : 3'b000;
    set  = (mode == M_SVC && off == 2) ? m_cap : 3'b000;
    ov_e = |(pend & set & ~clr);
    pend = (pend & ~clr) | set;
    case (mode)
      M_INIT: if (off == 2) mode = M_IDLE; else off++;
      M_IDLE: if (irq && en) begin mode = M_SVC; off = 1; end
      default: begin
        if (off == 1) m_cap = ec & 3'b111;
        if (off == 4 + H) mode = M_IDLE; else off++;
      end
    endcase
  endtask

  task automatic run_cycle(input logic rdy, input logic en, input logic rst,
                           input logic [2:0] edges, input logic firq);
    logic [2:0]  ec_n, mask_n;
    logic [31:0] rd_n;
    @(negedge clk);
    if (armed) begin
      compare_outputs();
      if (pio_chipselect && !pio_write_n) begin
        wlog.push_back(int'(pio_address) * 256 + int'(pio_writedata[7:0]));
        wcyc.push_back(cyc);
      end
      if (!pio_chipselect && pio_address == 2'd3) rd_cnt++;
      if (overflow) ov_cnt++;
      if (cmd_valid && !rdy && cmd_id == 2'd0) stall_cnt++;
      if (cmd_valid && rdy) begin
        $display("[cycle %0d] token accepted cmd_id=%0d", cyc, cmd_id);
        acc.push_back(int'(cmd_id));
        acc_cyc.push_back(cyc);
      end
    end
    cmd_ready = rdy;
    enable    = en;
    reset     = rst;
    rd_n = 32'h0;
    if (pio_address == 2'd3) rd_n = {29'b0, ec};
    else if (pio_address == 2'd2) rd_n = {29'b0, pio_mask};
    ec_n = ec;
    mask_n = pio_mask;
    if (armed && pio_chipselect && !pio_write_n) begin
      if (pio_address == 2'd3) ec_n = ec & ~pio_writedata[2:0];
      else if (pio_address == 2'd2) mask_n = pio_writedata[2:0];
    end
    ec_n = ec_n | edges;
    model_step(rdy, en, rst);
    @(posedge clk);
    #1;
    if (rst) armed = 1'b1;
    ec = ec_n;
    pio_mask = mask_n;
    pio_readdata = rd_n;
    irq = (|(ec & pio_mask)) | firq;
    cyc++;
  endtask

  task automatic clear_logs();
    wlog.delete(); wcyc.delete(); acc.delete(); acc_cyc.delete();
    ov_cnt = 0; rd_cnt = 0; stall_cnt = 0;
  endtask

  task automatic wait_quiet(input logic rdy, input logic need_empty, input string tag);
    int n = 0;
    while (!(mode == M_IDLE && !irq && (!need_empty || pend == 3'b000))) begin
      if (n >= 300) begin
        checks++;
        errors++;
        $display("FAIL %s: timeout, model mode=%0d, required idle", tag, mode);
        return;
      end
      run_cycle(rdy, 1'b1, 1'b0, 3'b000, 1'b0);
      n++;
    end
  endtask

  task automatic wait_pending(input string tag);
    int n = 0;
    while (pend == 3'b000) begin
      if (n >= 40) begin
        checks++;
        errors++;
        $display("FAIL %s: timeout, pending=0, required nonzero", tag);
        return;
      end
      run_cycle(1'b0, 1'b1, 1'b0, 3'b000, 1'b0);
      n++;
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and mask programming
    repeat (3) run_cycle(1'b1, 1'b1, 1'b1, 3'b000, 1'b0);
    chk("rst_busy", int'(busy), 1);
    chk("rst_cs", int'(pio_chipselect), 0);
    clear_logs();
    wait_quiet(1'b1, 1'b1, "init");
    chk("init_nwr", wlog.size(), 2);
    chk("init_wr0", q_at(wlog, 0), 'h207);
    chk("init_wr1", q_at(wlog, 1), 'h307);
    chk("init_gap", q_at(wcyc, 1) - q_at(wcyc, 0), 1);
    chk("init_busy", int'(busy), 0);

    // Single NEXT press
    clear_logs();
    run_cycle(1'b1, 1'b1, 1'b0, 3'b010, 1'b0);
    wait_quiet(1'b1, 1'b1, "next");
    chk("next_reads", rd_cnt, 1);
    chk("next_wr0", q_at(wlog, 0), 'h302);
    chk("next_wr1", q_at(wlog, 1), 'h307);
    chk("next_hold", q_at(wcyc, 1) - q_at(wcyc, 0), H + 1);
    chk("next_ntok", acc.size(), 1);
    chk("next_id", q_at(acc, 0), 1);

    // PLAY + PREV with back-pressure
    clear_logs();
    run_cycle(1'b0, 1'b1, 1'b0, 3'b101, 1'b0);
    wait_pending("pp");
    repeat (5) run_cycle(1'b0, 1'b1, 1'b0, 3'b000, 1'b0);
    wait_quiet(1'b1, 1'b1, "pp");
    chk("pp_stall", stall_cnt, 5);
    chk("pp_ntok", acc.size(), 2);
    chk("pp_id0", q_at(acc, 0), 0);
    chk("pp_id1", q_at(acc, 1), 2);
    chk("pp_gap", q_at(acc_cyc, 1) - q_at(acc_cyc, 0), 1);

    // Same button captured twice while still pending
    clear_logs();
    run_cycle(1'b0, 1'b1, 1'b0, 3'b001, 1'b0);
    wait_quiet(1'b0, 1'b0, "ov1");
    run_cycle(1'b0, 1'b1, 1'b0, 3'b001, 1'b0);
    wait_quiet(1'b0, 1'b0, "ov2");
    wait_quiet(1'b1, 1'b1, "ov3");
    chk("ov_pulses", ov_cnt, 1);
    chk("ov_ntok", acc.size(), 1);

    // Spurious interrupt with nothing captured
    clear_logs();
    run_cycle(1'b1, 1'b1, 1'b0, 3'b000, 1'b1);
    wait_quiet(1'b1, 1'b1, "spur");
    chk("spur_wr0", q_at(wlog, 0), 'h300);
    chk("spur_wr1", q_at(wlog, 1), 'h307);
    chk("spur_ntok", acc.size(), 0);
    chk("spur_ov", ov_cnt, 0);

    // Bounce edge during hold-off is flushed
    clear_logs();
    run_cycle(1'b1, 1'b1, 1'b0, 3'b010, 1'b0);
    repeat (8) run_cycle(1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
    run_cycle(1'b1, 1'b1, 1'b0, 3'b100, 1'b0);
    wait_quiet(1'b1, 1'b1, "bounce");
    chk("bounce_ntok", acc.size(), 1);
    chk("bounce_reads", rd_cnt, 1);

    // enable low holds off servicing
    clear_logs();
    run_cycle(1'b1, 1'b0, 1'b0, 3'b100, 1'b0);
    repeat (10) run_cycle(1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
    chk("en0_reads", rd_cnt, 0);
    wait_quiet(1'b1, 1'b1, "en1");
    chk("en1_id", q_at(acc, 0), 2);

    // Reset during hold-off
    clear_logs();
    run_cycle(1'b0, 1'b1, 1'b0, 3'b001, 1'b0);
    begin
      int n = 0;
      while (!(mode == M_SVC && off >= 8) && n < 40) begin
        run_cycle(1'b0, 1'b1, 1'b0, 3'b000, 1'b0);
        n++;
      end
    end
    run_cycle(1'b0, 1'b1, 1'b1, 3'b000, 1'b0);
    chk("hrst_valid", int'(cmd_valid), 0);
    chk("hrst_busy", int'(busy), 1);
    clear_logs();
    repeat (3) run_cycle(1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
    chk("hrst_wr0", q_at(wlog, 0), 'h207);
    wait_quiet(1'b1, 1'b1, "hrst");

    // Randomized traffic
    for (int i = 0; i < 2500; i++) begin
      logic       r, e, s, f;
      logic [2:0] ed;
      r  = ($urandom_range(0, 3) != 0);
      e  = ($urandom_range(0, 7) != 0);
      s  = ($urandom_range(0, 799) == 0);
      f  = ($urandom_range(0, 99) == 0);
      ed = ($urandom_range(0, 11) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      run_cycle(r, e, s, ed, f);
    end
    wait_quiet(1'b1, 1'b1, "rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_event_sequencer.md
Name: button_event_sequencer

Overview:
Avalon-MM master that owns the 3-bit button PIO slave (edge-capture, irq-mask, data registers) on behalf of the audio player. It programs the IRQ mask after reset and services the PIO interrupt: read edge_capture, clear it, run a debounce hold-off, then flush bounce edges. Captured edges become single-cycle command tokens (e.g. play/pause, next, previous) on a valid/ready stream toward the playback control FSM.

Parameters:
NUM_BTN, 3, number of buttons; equals PIO width. Fixed at 3 for this design.
IRQ_MASK, 3'b111, value written to PIO address 2 after reset.
HOLDOFF_CYCLES, 2500000, debounce hold-off length in clk cycles (50 ms at 50 MHz). Must be >= 1.
CNT_W, 22, hold-off counter width. Must satisfy 2^CNT_W > HOLDOFF_CYCLES.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  1 = service interrupts; 0 = stay in IDLE after current sequence completes
irq  in  1  PIO interrupt (edge_capture & irq_mask != 0)
pio_address  out  2  PIO register select
pio_chipselect  out  1  PIO chipselect; asserted only on write cycles
pio_write_n  out  1  PIO write strobe, active low
pio_writedata  out  32  PIO write data; bits 31:NUM_BTN always 0
pio_readdata  in  32  PIO read data; registered in the PIO, 1-cycle latency from address
cmd_valid  out  1  command token available
cmd_id  out  2  button index of current token (0..NUM_BTN-1)
cmd_ready  in  1  consumer accepts token
busy  out  1  FSM not in IDLE
overflow  out  1  1-cycle pulse: a captured edge merged into an already-pending bit

Behaviour:
- Reset values:
  - State = INIT_MASK.
  - pio_address = 0, pio_chipselect = 0, pio_write_n = 1, pio_writedata = 0.
  - pending = 0, cmd_valid = 0, cmd_id = 0, overflow = 0.
  - Hold-off counter = 0. busy = 1, because INIT_MASK is not IDLE.
- All outputs are registered.
- Bus writes: one-cycle strobe (chipselect = 1, write_n = 0) with address and writedata valid in the same cycle. No wait states.
- Bus reads: drive the address with chipselect = 0 and write_n = 1. Sample pio_readdata one cycle later.
- States:
  - INIT_MASK: write addr 2 = IRQ_MASK. Next state is FLUSH, which clears stale captures.
  - IDLE: when irq & enable, go to RD_REQ. Otherwise remain.
  - RD_REQ: pio_address = 3. Go to RD_WAIT.
  - RD_WAIT:
    - cap = pio_readdata[NUM_BTN-1:0] & IRQ_MASK.
    - pending <= pending | cap.
    - overflow pulses if (pending & cap) != 0.
    - Go to CLR.
  - CLR: write addr 3 = cap (write-1-to-clear). Load counter = HOLDOFF_CYCLES-1. Go to HOLD.
  - HOLD: decrement the counter each cycle. At 0, go to FLUSH.
  - FLUSH: write addr 3 = all ones (NUM_BTN bits), discarding bounce edges captured during hold-off. Go to IDLE.
- Latency: irq at IDLE to the pending bit set is 3 cycles (IDLE → RD_REQ → RD_WAIT).
- cap = 0 (spurious irq): pending is unchanged and the CLR write of 0 still occurs. The sequence completes normally.
- Command stream (independent of FSM state):
  - cmd_valid = (pending != 0). cmd_id = index of the lowest set bit of pending.
  - On cmd_valid & cmd_ready, clear that bit next cycle.
  - Tokens are stable while cmd_valid & !cmd_ready.
  - If a set (RD_WAIT) and a clear (handshake) hit the same bit in one cycle, the set wins: the bit stays 1, and overflow does not pulse for it.
  - Throughput: 1 token per cycle.
- enable deassertion mid-sequence does not abort the sequence; it completes to IDLE.
- irq held high during HOLD is ignored. It is re-evaluated in IDLE; FLUSH normally drops it.
- busy = (state != IDLE).

Decomposition:
- Package button_seq_pkg holds:
  - State enum: INIT_MASK, IDLE, RD_REQ, RD_WAIT, CLR, HOLD, FLUSH.
  - PIO register address constants: ADDR_DATA = 0, ADDR_MASK = 2, ADDR_EDGE = 3.
  - Button index constants: BTN_PLAY = 0, BTN_NEXT = 1, BTN_PREV = 2.
- One natural sub-module, button_cmd_queue: the pending register, the lowest-set-bit priority encoder, the valid/ready handshake, and overflow detection.

Test Plan:
- Reset release → cycle 1: write addr 2 data 0x7. Cycle 2: write addr 3 data 0x7. Then IDLE with busy = 0 and cmd_valid = 0.
- irq with edge_capture = 3'b010 and cmd_ready = 1 → read addr 3, write addr 3 = 0x2, HOLD for exactly 16 cycles (HOLDOFF_CYCLES = 16), write addr 3 = 0x7. One token cmd_id = 1 is emitted.
- edge_capture = 3'b101 with cmd_ready = 0 for 5 cycles, then 1 → cmd_id = 0 is stable for 5 cycles. Then cmd_id = 0 and cmd_id = 2 are accepted on consecutive cycles, and cmd_valid drops after that.
- pending = 3'b001 with cmd_ready = 0, new irq with capture 3'b001 → overflow pulses for 1 cycle. Exactly one token results.
- irq with readdata = 0 → CLR writes 0x0, FLUSH writes 0x7, no token, overflow = 0.
- reset asserted during HOLD → next cycle: state INIT_MASK, pending = 0, cmd_valid = 0. The INIT_MASK write of 0x7 to addr 2 follows after reset deasserts.
